// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// mmio_pkg : FSM states, default I/O addresses and 7-segment table for
//            the MMIO bus controller.          Rev 1.0
// ============================================================================
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [8:0] MMIO_LED_ADDR = 9'h100;
  localparam logic [8:0] MMIO_SW_ADDR  = 9'h140;
  localparam logic [8:0] MMIO_HEX_ADDR = 9'h180;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
// bus_ram : single-port synchronous RAM, registered read, write-first.
//           Rev 1.0
// ============================================================================
module bus_ram #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(RAM_DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
      rdata       <= wdata;
    end else begin
      rdata       <= mem_q[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// mmio_bus_ctrl : RAM / switch / LED bus controller for the SRM CPU.
//                 MMIO_HEX_EN adds a 4-digit 7-segment register at 9'h180.
//                 Rev 1.0
// ============================================================================
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       RAM_DEPTH = 256,
  parameter int unsigned       SW_W      = 10,
  parameter int unsigned       LED_W     = 10,
  parameter logic [ADDR_W-1:0] SW_ADDR   = ADDR_W'(MMIO_SW_ADDR),
  parameter logic [ADDR_W-1:0] LED_ADDR  = ADDR_W'(MMIO_LED_ADDR),
  parameter int unsigned       READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led
`ifdef MMIO_HEX_EN
  ,
  output logic [27:0]       hex
`endif
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

  generate
    if (32'(SW_ADDR) < RAM_DEPTH || 32'(LED_ADDR) < RAM_DEPTH) begin : g_bad_io_addr
      $error("mmio_bus_ctrl: I/O address inside RAM range");
    end
    if (READ_WAIT > 7) begin : g_bad_read_wait
      $error("mmio_bus_ctrl: READ_WAIT must be 0..7");
    end
  endgenerate

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [2:0]        cnt_q;
  logic [RAM_AW-1:0] addr_q;
  logic              sel_ram_q;
  logic              err_q;
  logic [DATA_W-1:0] io_rdata_q;
  logic [LED_W-1:0]  led_q;
  logic [SW_W-1:0]   sw_meta_q;
  logic [SW_W-1:0]   sw_sync_q;

  logic              w_in_ram;
  logic              w_is_led;
  logic              w_is_sw;
  logic              w_is_hex;
  logic              w_err;
  logic [DATA_W-1:0] w_io_rdata;
  logic              w_ram_we;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_rdata;

`ifdef MMIO_HEX_EN
  localparam logic [ADDR_W-1:0] HEX_ADDR = ADDR_W'(MMIO_HEX_ADDR);
  logic [15:0] hex_q;

  generate
    if (32'(HEX_ADDR) < RAM_DEPTH) begin : g_bad_hex_addr
      $error("mmio_bus_ctrl: HEX address inside RAM range");
    end
  endgenerate

  assign hex = {seg7(hex_q[15:12]), seg7(hex_q[11:8]), seg7(hex_q[7:4]), seg7(hex_q[3:0])};
`endif

  // Decode priority: RAM range, then LED, then switches, then HEX.
  always_comb begin
    w_in_ram   = 32'(req_addr) < RAM_DEPTH;
    w_is_led   = !w_in_ram && (req_addr == LED_ADDR);
    w_is_sw    = !w_in_ram && !w_is_led && (req_addr == SW_ADDR);
    w_is_hex   = 1'b0;
`ifdef MMIO_HEX_EN
    w_is_hex   = !w_in_ram && !w_is_led && !w_is_sw && (req_addr == HEX_ADDR);
`endif
    w_err      = !(w_in_ram || w_is_led || w_is_hex || (w_is_sw && !req_write));
    w_io_rdata = '0;
    if (w_is_led) begin
      w_io_rdata = DATA_W'(led_q);
    end else if (w_is_sw) begin
      w_io_rdata = DATA_W'(sw_sync_q);
`ifdef MMIO_HEX_EN
    end else if (w_is_hex) begin
      w_io_rdata = DATA_W'(hex_q);
`endif
    end
  end

  // The RAM follows the live address only while idle so its read data
  // stays parked on the accepted word through WAIT and RESP.
  assign w_ram_we   = (state_q == IDLE) && req_valid && req_write && w_in_ram;
  assign w_ram_addr = (state_q == IDLE) ? req_addr[RAM_AW-1:0] : addr_q;

  bus_ram #(
    .DATA_W    (DATA_W),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (req_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      sel_ram_q   <= 1'b0;
      err_q       <= 1'b0;
      io_rdata_q  <= '0;
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
`ifdef MMIO_HEX_EN
      hex_q       <= '0;
`endif
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr[RAM_AW-1:0];
            sel_ram_q   <= w_in_ram && !req_write;
            err_q       <= w_err;
            io_rdata_q  <= req_write ? '0 : w_io_rdata;
            req_ready_q <= 1'b0;
            if (req_write && w_is_led) begin
              led_q <= req_wdata[LED_W-1:0];
            end
`ifdef MMIO_HEX_EN
            if (req_write && w_is_hex) begin
              hex_q <= req_wdata[15:0];
            end
`endif
            if (!req_write && READ_WAIT != 0) begin
              state_q <= WAIT;
              cnt_q   <= 3'(READ_WAIT);
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 3'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & err_q;
  assign rsp_rdata = !rsp_valid_q ? '0 : (sel_ram_q ? w_ram_rdata : io_rdata_q);
  assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mmio_bus_ctrl : table-driven bench for mmio_bus_ctrl; instance 0 uses
//                    READ_WAIT=0, instance 1 uses READ_WAIT=3.   Rev 1.0
// ============================================================================
module tb_mmio_bus_ctrl;

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        err;
    logic [9:0]  led1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  sw = '0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [8:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [9:0]  led       [2];
`ifdef MMIO_HEX_EN
  logic [27:0] hex0, hex1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl #(.READ_WAIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .sw(sw), .led(led[0])
`ifdef MMIO_HEX_EN
    , .hex(hex0)
`endif
  );

  mmio_bus_ctrl #(.READ_WAIT(3)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .sw(sw), .led(led[1])
`ifdef MMIO_HEX_EN
    , .hex(hex1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered just after a negedge; returns just after a negedge.
  task automatic txn(input int d, input logic w, input logic [8:0] a, input logic [15:0] wd,
                     input bit pulse, output logic [15:0] rd, output logic er, output int lat,
                     output logic busy_rdy, output logic rdy_after, output logic [9:0] led1);
    req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_write[d] = ~w; req_addr[d] = ~a; req_wdata[d] = ~wd;
    lat = 99; rd = '0; er = 1'b0; busy_rdy = 1'b0; led1 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) led1 = led[d];
      busy_rdy = busy_rdy | req_ready[d];
      if (rsp_valid[d]) begin
        lat = i; rd = rsp_rdata[d]; er = rsp_err[d];
        break;
      end
      if (pulse) begin
        req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 9'h100; req_wdata[d] = 16'hFFFF;
      end
    end
    req_valid[d] = 1'b0;
    @(negedge clk);
    rdy_after = req_ready[d];
  endtask

  initial begin
    vec_t        tbl[$];
    logic [15:0] rd;
    logic        er, busy, rdy_after;
    logic [9:0]  l1;
    int          lat;
    logic        seen;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    tbl.push_back('{1'b1, 9'h005, 16'hBEEF, 16'h0000, 1'b0, 10'h000});
    tbl.push_back('{1'b0, 9'h005, 16'h0000, 16'hBEEF, 1'b0, 10'h000});
    tbl.push_back('{1'b1, 9'h000, 16'h1234, 16'h0000, 1'b0, 10'h000});
    tbl.push_back('{1'b1, 9'h0FF, 16'hA5A5, 16'h0000, 1'b0, 10'h000});
    tbl.push_back('{1'b0, 9'h000, 16'h0000, 16'h1234, 1'b0, 10'h000});
    tbl.push_back('{1'b0, 9'h0FF, 16'h0000, 16'hA5A5, 1'b0, 10'h000});
    tbl.push_back('{1'b1, 9'h0F0, 16'h0000, 16'h0000, 1'b0, 10'h000});
    tbl.push_back('{1'b1, 9'h1F0, 16'h5555, 16'h0000, 1'b1, 10'h000});
    tbl.push_back('{1'b0, 9'h0F0, 16'h0000, 16'h0000, 1'b0, 10'h000});
    tbl.push_back('{1'b0, 9'h1F0, 16'h0000, 16'h0000, 1'b1, 10'h000});
    tbl.push_back('{1'b1, 9'h100, 16'hFFFF, 16'h0000, 1'b0, 10'h3FF});
    tbl.push_back('{1'b0, 9'h100, 16'h0000, 16'h03FF, 1'b0, 10'h3FF});
    tbl.push_back('{1'b0, 9'h101, 16'h0000, 16'h0000, 1'b1, 10'h3FF});
    tbl.push_back('{1'b0, 9'h140, 16'h0000, 16'h02A5, 1'b0, 10'h3FF});
    tbl.push_back('{1'b1, 9'h140, 16'h0001, 16'h0000, 1'b1, 10'h3FF});
`ifdef MMIO_HEX_EN
    tbl.push_back('{1'b0, 9'h180, 16'h0000, 16'h0000, 1'b0, 10'h3FF});
`else
    tbl.push_back('{1'b0, 9'h180, 16'h0000, 16'h0000, 1'b1, 10'h3FF});
`endif
    tbl.push_back('{1'b1, 9'h100, 16'h0155, 16'h0000, 1'b0, 10'h155});
    tbl.push_back('{1'b0, 9'h100, 16'h0000, 16'h0155, 1'b0, 10'h155});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sw = 10'h2A5;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ready%0d", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset_rdata%0d", d), 32'(rsp_rdata[d]), 32'd0);
      check($sformatf("reset_err%0d", d), 32'(rsp_err[d]), 32'd0);
      check($sformatf("reset_led%0d", d), 32'(led[d]), 32'd0);
    end
    repeat (3) @(negedge clk);

    foreach (tbl[k]) begin
      txn(0, tbl[k].w, tbl[k].a, tbl[k].wd, 1'b0, rd, er, lat, busy, rdy_after, l1);
      check($sformatf("v%0d_lat", k), 32'(lat), 32'd1);
      check($sformatf("v%0d_rdata", k), 32'(rd), 32'(tbl[k].rd));
      check($sformatf("v%0d_err", k), 32'(er), 32'(tbl[k].err));
      check($sformatf("v%0d_led", k), 32'(l1), 32'(tbl[k].led1));
      check($sformatf("v%0d_busy_ready", k), 32'(busy), 32'd0);
      check($sformatf("v%0d_ready_after", k), 32'(rdy_after), 32'd1);
    end

`ifdef MMIO_HEX_EN
    txn(0, 1'b1, 9'h180, 16'h12AF, 1'b0, rd, er, lat, busy, rdy_after, l1);
    check("hex_wr_err", 32'(er), 32'd0);
    check("hex_digit0", 32'(hex0[6:0]), 32'h0E);
    check("hex_digit3", 32'(hex0[27:21]), 32'h79);
    check("hex_all", 32'(hex0), 32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
    txn(0, 1'b0, 9'h180, 16'h0000, 1'b0, rd, er, lat, busy, rdy_after, l1);
    check("hex_rd", 32'(rd), 32'h12AF);
`else
    txn(0, 1'b1, 9'h180, 16'h12AF, 1'b0, rd, er, lat, busy, rdy_after, l1);
    check("hex_unmapped_err", 32'(er), 32'd1);
`endif

    // READ_WAIT=3 instance: latency and ignored requests during WAIT
    txn(1, 1'b1, 9'h005, 16'hBEEF, 1'b0, rd, er, lat, busy, rdy_after, l1);
    check("w3_wr_lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 9'h005, 16'h0000, 1'b1, rd, er, lat, busy, rdy_after, l1);
    check("w3_rd_lat", 32'(lat), 32'd4);
    check("w3_rd_data", 32'(rd), 32'hBEEF);
    check("w3_busy_ready", 32'(busy), 32'd0);
    check("w3_ready_after", 32'(rdy_after), 32'd1);
    check("w3_led_untouched", 32'(led[1]), 32'd0);

    // Reset during WAIT drops the response but not the RAM contents
    txn(1, 1'b1, 9'h100, 16'h0333, 1'b0, rd, er, lat, busy, rdy_after, l1);
    check("w3_led_set", 32'(l1), 32'h333);
    req_write[1] = 1'b0; req_addr[1] = 9'h005; req_valid[1] = 1'b1;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_wait_ready", 32'(req_ready[1]), 32'd1);
    check("rst_wait_led", 32'(led[1]), 32'd0);
    check("rst_led_dut0", 32'(led[0]), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rsp_valid[1];
    end
    check("rst_no_late_rsp", 32'(seen), 32'd0);
    txn(1, 1'b0, 9'h005, 16'h0000, 1'b0, rd, er, lat, busy, rdy_after, l1);
    check("rst_ram_kept_lat", 32'(lat), 32'd4);
    check("rst_ram_kept_data", 32'(rd), 32'hBEEF);
    check("rst_ram_kept_err", 32'(er), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
